// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : handshake bundle between requesters, memory and arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
    logic [2:0] req_i;
    logic [2:0] we_i;
    logic       mem_ready_i;
    logic [1:0] sel_o;
    logic       mem_req_o;
    logic       mem_we_o;
    logic [2:0] gnt_o;
    logic [2:0] done_o;
    logic [2:0] stall_o;
    logic       err_o;

    // Arbiter side
    modport slave (
        input  req_i,
        input  we_i,
        input  mem_ready_i,
        output sel_o,
        output mem_req_o,
        output mem_we_o,
        output gnt_o,
        output done_o,
        output stall_o,
        output err_o
    );

    // Requester / memory side
    modport master (
        output req_i,
        output we_i,
        output mem_ready_i,
        input  sel_o,
        input  mem_req_o,
        input  mem_we_o,
        input  gnt_o,
        input  done_o,
        input  stall_o,
        input  err_o
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin owner of the shared memory port, with watchdog
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_BITS       = 5
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [CNT_BITS-1:0] C_TMO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]          C_LOADER   = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              state_q;
    logic [1:0]          owner_q;
    logic [1:0]          last_q;
    logic                we_q;
    logic                mem_req_q;
    logic [2:0]          gnt_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                err_q;

    logic [1:0]          w_c1;
    logic [1:0]          w_c2;
    logic [1:0]          w_winner;
    logic                w_timeout;
    logic                w_finish;
    logic [2:0]          w_done;

    function automatic logic [1:0] f_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search order starts just after the previous owner; the previous owner
    // itself is the last candidate, so it wins only when nobody else asks.
    assign w_c1 = f_next(last_q);
    assign w_c2 = f_next(w_c1);

    always_comb begin
        w_winner = last_q;
        if (bus.req_i[w_c1]) begin
            w_winner = w_c1;
        end else if (bus.req_i[w_c2]) begin
            w_winner = w_c2;
        end
    end

    assign w_timeout = (cnt_q == C_TMO_LAST);
    // A reset cycle must not look like a completion to the owner.
    assign w_finish  = (state_q == ST_ACCESS) && (bus.mem_ready_i || w_timeout) && !reset;
    assign w_done    = w_finish ? gnt_q : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'd0;
            last_q    <= C_LOADER;
            we_q      <= 1'b0;
            mem_req_q <= 1'b0;
            gnt_q     <= 3'b000;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req_i) begin
                        owner_q   <= w_winner;
                        we_q      <= bus.we_i[w_winner];
                        gnt_q     <= 3'b001 << w_winner;
                        mem_req_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (bus.mem_ready_i || w_timeout) begin
                        if (!bus.mem_ready_i) begin
                            err_q <= 1'b1;
                        end
                        last_q    <= owner_q;
                        cnt_q     <= '0;
                        gnt_q     <= 3'b000;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel_o     = owner_q;
    assign bus.mem_req_o = mem_req_q;
    assign bus.mem_we_o  = we_q;
    assign bus.gnt_o     = gnt_q;
    assign bus.done_o    = w_done;
    assign bus.stall_o   = bus.req_i & ~w_done;
    assign bus.err_o     = err_q;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port of the pipelined RISC-V core between three requesters: instruction fetch (0), data access from the MEM stage (1) and the boot loader (2).
- Drives the 2-bit selector of the 3-to-1 address/write-data multiplexer in front of the memory.
- Provides fair round-robin arbitration with a variable-latency memory handshake.
- Flags a stuck memory with a watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles without mem_ready_i before the transfer is aborted.
- CNT_BITS, 5: width of the watchdog counter; must satisfy 2^CNT_BITS > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_i  input  3  per-requester request; bit0 fetch, bit1 data, bit2 loader
- we_i  input  3  per-requester write enable, sampled at grant
- mem_ready_i  input  1  memory completes the current access this cycle
- sel_o  output  2  mux selector: 00 fetch, 01 data, 10 loader; never 11
- mem_req_o  output  1  access in progress toward memory
- mem_we_o  output  1  write enable of the granted access
- gnt_o  output  3  one-hot owner of the port; zero in IDLE
- done_o  output  3  one-cycle completion pulse to the owner
- stall_o  output  3  per-requester stall: req_i[n] & ~done_o[n]
- err_o  output  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - state = IDLE
  - sel_o = 00, gnt_o = 000, done_o = 000
  - mem_req_o = 0, mem_we_o = 0, err_o = 0
  - watchdog counter = 0
  - last_owner = 2, so the first priority goes to fetch
- State machine: two states, IDLE and ACCESS.
- IDLE:
  - If req_i != 0, select the winner by searching (last_owner+1), (last_owner+2), (last_owner+3), all mod 3.
  - Register owner = winner, sel_o = winner, mem_we_o = we_i[winner].
  - Next state is ACCESS.
  - If req_i == 0, remain in IDLE; sel_o holds its previous value.
- ACCESS:
  - mem_req_o = 1 and gnt_o = onehot(owner).
  - sel_o, owner and mem_we_o stay stable for the whole access.
  - The watchdog counter increments each ACCESS cycle in which mem_ready_i = 0.
- Completion (ACCESS and mem_ready_i = 1):
  - done_o[owner] = 1 combinationally in that same cycle.
  - Next edge: last_owner = owner, counter cleared, state returns to IDLE.
- Latency:
  - Request seen in IDLE at edge k: mem_req_o is high from cycle k+1.
  - Minimum turnaround is 2 cycles per transfer: one IDLE arbitration cycle plus one ACCESS cycle with immediate ready.
  - Back-to-back transfers therefore always have one IDLE bubble.
- Timeout:
  - Applies when the counter reaches TIMEOUT_CYCLES-1 with mem_ready_i still 0 (i.e. the TIMEOUT_CYCLES-th ACCESS cycle without ready).
  - done_o[owner] pulses in that cycle (transfer abandoned).
  - err_o is set at the next edge and stays set until reset.
  - The state returns to IDLE and last_owner advances as for a normal completion.
- Ready in the same cycle as the timeout: counts as a normal completion; err_o is not set.
- Requester handshake:
  - A requester holds req_i until it sees done_o.
  - If req_i drops during ACCESS, the access still runs to completion and done_o is still pulsed; memory accesses cannot be cancelled.
  - we_i changes after the grant are ignored.
- mem_ready_i while in IDLE is ignored.
- Reset mid-ACCESS: the next edge forces IDLE with mem_req_o = 0; no done_o pulse is generated.
- stall_o is combinational and is valid in both states, including for requesters that are not currently granted.

Test Plan:
1. Single fetch, ready asserted in the first ACCESS cycle:
   - Stimulus: req_i=001 held; mem_ready_i=1 in the first ACCESS cycle.
   - Required: sel_o=00, mem_req_o high exactly 1 cycle, done_o=001 in that cycle, stall_o[0] clears with done.
2. All three requesting continuously, ready always 1:
   - Grant order: 0, 1, 2, 0, 1, 2.
   - sel_o sequence 00, 01, 10, 00.
   - Each transfer takes 2 cycles; sel_o never equals 11.
3. Data write with 3-cycle memory latency:
   - Stimulus: req_i=010, we_i=010; mem_ready_i=1 only on the 3rd ACCESS cycle.
   - Required: mem_we_o=1 and sel_o=01 stable for 3 cycles; done_o=010 on cycle 3; err_o stays 0.
4. Stuck memory with TIMEOUT_CYCLES=16:
   - Stimulus: loader request; mem_ready_i held 0.
   - Required: done_o=100 on the 16th ACCESS cycle; err_o=1 from the next edge onward; the next fetch request is still granted.
5. Reset asserted on the 2nd ACCESS cycle of a data access:
   - Next edge: mem_req_o=0, gnt_o=000, no done_o pulse.
   - After release, req_i=011 grants fetch first (last_owner reset to 2).
6. Requester withdraws during ACCESS:
   - Stimulus: req_i[1] dropped in the 1st ACCESS cycle; ready arrives on the 2nd.
   - Required: done_o=010 pulses on the 2nd cycle; the next arbitration starts from owner 2.
